// File: rtl/blocking_out_sender_pkg.sv
// Shared types for the blocking-out sender: FSM state encoding and counter width.
package sender_types;

    typedef enum logic {IDLE, SEND} sender_state_t;

    localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/blocking_out_sender_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on dout whenever not empty.
module sync_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally; a push while full is legal only together with a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/blocking_out_sender.sv
// Producer end of a shadow-in / blocking-out channel: buffers published words
// and offers them in order over a notify/sync handshake, counting overflow drops.
module blocking_out_sender
    import sender_types::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             m_in,
    input  logic                     m_in_notify,
    output logic [W-1:0]             b_out,
    output logic                     b_out_notify,
    input  logic                     b_out_sync,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    sender_state_t          state;
    sender_state_t          state_d;
    logic [W-1:0]           b_out_d;
    logic                   notify_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_d;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   full;
    logic                   empty;
    logic [W-1:0]           head;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (m_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push = m_in_notify & (~full | pop);
    assign drop = m_in_notify & full & ~pop;

    // Next-state and output-register logic.
    always_comb begin
        state_d    = state;
        b_out_d    = b_out;
        notify_d   = b_out_notify;
        pop        = 1'b0;
        drop_cnt_d = drop_cnt;
        case (state)
            IDLE: begin
                if (!empty) begin
                    b_out_d  = head;
                    notify_d = 1'b1;
                    pop      = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (b_out_sync) begin
                    if (!empty) begin
                        b_out_d = head;
                        pop     = 1'b1;
                    end else begin
                        notify_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                notify_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
        if (drop && (drop_cnt != '1)) begin
            drop_cnt_d = drop_cnt + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            b_out        <= '0;
            b_out_notify <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            state        <= state_d;
            b_out        <= b_out_d;
            b_out_notify <= notify_d;
            drop_cnt     <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_blocking_out_sender.sv
// Directed bench for blocking_out_sender with a queue-based reference model.
module tb_blocking_out_sender;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  m_in = '0;
    logic          m_in_notify = 1'b0;
    logic [W-1:0]  b_out;
    logic          b_out_notify;
    logic          b_out_sync = 1'b0;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending words, offered word, drop count.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_out;
    logic         m_valid;
    int           m_drop;
    logic [W-1:0] dut_xfers[$];

    always #5 clk = ~clk;

    blocking_out_sender #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_in         (m_in),
        .m_in_notify  (m_in_notify),
        .b_out        (b_out),
        .b_out_notify (b_out_notify),
        .b_out_sync   (b_out_sync),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_drop  = 0;
    endtask

    // One clock of channel behaviour: offer advances when idle or accepted, then capture.
    task automatic model_clock(input logic notify, input logic [W-1:0] data, input logic sync);
        if (!m_valid || sync) begin
            if (mq.size() > 0) begin
                m_out   = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (notify) begin
            if (mq.size() < DEPTH) mq.push_back(data);
            else if (m_drop < 65535) m_drop++;
        end
    endtask

    task automatic compare_model();
        check("b_out_notify", W'(b_out_notify), W'(m_valid));
        check("b_out", b_out, m_out);
        check("fifo_level", W'(fifo_level), W'(mq.size()));
        check("drop_cnt", W'(drop_cnt), W'(m_drop));
    endtask

    task automatic step(input logic notify, input logic [W-1:0] data, input logic sync);
        m_in        = data;
        m_in_notify = notify;
        b_out_sync  = sync;
        #3;
        if (b_out_notify && b_out_sync) dut_xfers.push_back(b_out);
        @(posedge clk);
        model_clock(notify, data, sync);
        #1;
        compare_model();
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear immediately.
    task automatic pulse_reset();
        m_in_notify = 1'b0;
        b_out_sync  = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_notify", W'(b_out_notify), '0);
        check("rst_level", W'(fifo_level), '0);
        compare_model();
        #1;
        rst = 1'b0;
        dut_xfers.delete();
    endtask

    initial begin
        model_reset();
        #12;
        check("por_b_out", b_out, '0);
        compare_model();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word latency
        pulse_reset();
        step(1'b1, 32'd42, 1'b1);
        check("t1_c1_notify", W'(b_out_notify), '0);
        step(1'b0, 32'd0, 1'b1);
        check("t1_c2_notify", W'(b_out_notify), 32'd1);
        check("t1_c2_b_out", b_out, 32'd42);
        step(1'b0, 32'd0, 1'b1);
        check("t1_c3_notify", W'(b_out_notify), '0);
        check("t1_c3_b_out_kept", b_out, 32'd42);

        // Backpressure then back-to-back drain
        pulse_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, W'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b0);
        check("t2_b_out", b_out, 32'd1);
        check("t2_level", W'(fifo_level), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
        check("t2_xfer_cnt", W'(dut_xfers.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("t2_xfer_word", dut_xfers[i], W'(i + 1));
        check("t2_idle_notify", W'(b_out_notify), '0);

        // Overflow
        pulse_reset();
        for (int i = 10; i <= 15; i++) step(1'b1, W'(i), 1'b0);
        check("t3_b_out", b_out, 32'd10);
        check("t3_level", W'(fifo_level), 32'd4);
        check("t3_drop", W'(drop_cnt), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 1'b1);
        check("t3_xfer_cnt", W'(dut_xfers.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("t3_xfer_word", dut_xfers[i], W'(10 + i));

        // Push and pop while full
        pulse_reset();
        for (int i = 20; i <= 24; i++) step(1'b1, W'(i), 1'b0);
        check("t4_pre_level", W'(fifo_level), 32'd4);
        step(1'b1, 32'd25, 1'b1);
        check("t4_level", W'(fifo_level), 32'd4);
        check("t4_drop", W'(drop_cnt), '0);
        check("t4_b_out", b_out, 32'd21);
        for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 1'b1);
        check("t4_xfer_cnt", W'(dut_xfers.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("t4_xfer_word", dut_xfers[i], W'(20 + i));

        // Mixed traffic with intermittent acceptance
        pulse_reset();
        for (int i = 0; i < 48; i++) step(logic'((i % 3) != 0), W'(100 + i), logic'((i % 5) < 2));
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1);

        // Drop counter saturation: 5 accepted words then 65540 drops
        pulse_reset();
        for (int i = 0; i < 65545; i++) step(1'b1, W'(i), 1'b0);
        check("t5_drop_sat", W'(drop_cnt), 32'hFFFF);
        step(1'b1, 32'd7, 1'b0);
        check("t5_no_wrap", W'(drop_cnt), 32'hFFFF);

        // Reset in the middle of an offer
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b1, W'(60 + i), 1'b0);
        check("t6_pre_level", W'(fifo_level), 32'd3);
        check("t6_pre_notify", W'(b_out_notify), 32'd1);
        pulse_reset();
        step(1'b1, 32'd77, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        check("t6_post_notify", W'(b_out_notify), 32'd1);
        check("t6_post_b_out", b_out, 32'd77);
        step(1'b0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
